// File: rtl/emu_ram_ckpt_ctrl.sv
// Checkpoint controller for an emulated RAM scan chain: pauses the DUT clock,
// streams chain words out (save) or in (load), then resumes and drains.
module emu_ram_ckpt_ctrl #(
    parameter int DATA_WIDTH  = 64,
    parameter int CHAIN_WORDS = 16,
    parameter int SAVE_LAT    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_load,
    output logic                  pause,
    output logic                  emu_ram_se,
    output logic                  emu_ram_sd,
    output logic [DATA_WIDTH-1:0] emu_ram_di,
    input  logic [DATA_WIDTH-1:0] emu_ram_do,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [DATA_WIDTH-1:0] dout_data,
    input  logic                  din_valid,
    output logic                  din_ready,
    input  logic [DATA_WIDTH-1:0] din_data,
    output logic                  busy,
    output logic                  done
);
    typedef enum logic [3:0] {
        IDLE, PAUSE, FILL, SAVE, LOAD, FLUSH, UNSCAN, RESUME, DRAIN
    } state_t;

    localparam logic [15:0] LAST_WORD = 16'(CHAIN_WORDS - 1);
    localparam logic [3:0]  LAST_FILL = 4'((SAVE_LAT == 0) ? 0 : SAVE_LAT - 1);

    state_t state, state_nxt;
    logic        load_q;
    logic [15:0] word_cnt;
    logic [3:0]  fill_cnt;

    logic [DATA_WIDTH-1:0] fifo_mem [4];
    logic [1:0]  wr_ptr, rd_ptr;
    logic [2:0]  fifo_cnt;
    logic        fifo_full, fifo_empty, push, pop, accept, load_hs;

    assign fifo_full  = (fifo_cnt == 3'd4);
    assign fifo_empty = (fifo_cnt == 3'd0);
    assign dout_valid = !fifo_empty;
    assign dout_data  = fifo_mem[rd_ptr];
    assign pop        = dout_valid && dout_ready;

    always_comb begin
        state_nxt  = state;
        cmd_ready  = 1'b0;
        pause      = 1'b1;
        busy       = 1'b1;
        emu_ram_se = 1'b0;
        emu_ram_sd = load_q;
        emu_ram_di = '0;
        din_ready  = 1'b0;
        done       = 1'b0;
        push       = 1'b0;
        accept     = 1'b0;
        load_hs    = 1'b0;
        case (state)
            IDLE: begin
                pause      = 1'b0;
                busy       = 1'b0;
                emu_ram_sd = 1'b0;
                cmd_ready  = !rst;
                accept     = cmd_valid && !rst;
                if (accept) state_nxt = PAUSE;
            end
            PAUSE: begin
                if (load_q)             state_nxt = LOAD;
                else if (SAVE_LAT == 0) state_nxt = SAVE;
                else                    state_nxt = FILL;
            end
            FILL: begin
                emu_ram_se = 1'b1;
                if (fill_cnt == LAST_FILL) state_nxt = SAVE;
            end
            SAVE: begin
                // Holding se low while full freezes the chain so a dout stall never drops a word
                emu_ram_se = !fifo_full;
                push       = !fifo_full;
                if (push && word_cnt == LAST_WORD) state_nxt = UNSCAN;
            end
            LOAD: begin
                din_ready  = 1'b1;
                emu_ram_se = din_valid;
                emu_ram_di = din_data;
                load_hs    = din_valid;
                if (load_hs && word_cnt == LAST_WORD) state_nxt = FLUSH;
            end
            FLUSH: begin
                emu_ram_se = 1'b1;
                state_nxt  = UNSCAN;
            end
            UNSCAN: state_nxt = RESUME;
            RESUME: state_nxt = DRAIN;
            DRAIN: begin
                pause      = 1'b0;
                emu_ram_sd = 1'b0;
                if (fifo_empty) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            load_q   <= 1'b0;
            word_cnt <= '0;
            fill_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                load_q   <= cmd_load;
                word_cnt <= '0;
            end else if (push || load_hs) begin
                word_cnt <= word_cnt + 16'd1;
            end
            if (state == PAUSE)     fill_cnt <= '0;
            else if (state == FILL) fill_cnt <= fill_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            fifo_cnt <= fifo_cnt + 3'(push) - 3'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= emu_ram_do;
    end
endmodule

// File: tb/tb_emu_ram_ckpt_ctrl.sv
// Randomized scoreboard bench: a behavioural scan-chain RAM model feeds the
// controller; saved words are checked in order and loads must restore the RAM.
module tb_emu_ram_ckpt_ctrl;
    localparam int DW  = 80;
    localparam int CW  = 16;
    localparam int LAT = 2;
    typedef logic [DW-1:0] word_t;

    logic clk = 0, rst = 1;
    logic cmd_valid = 0, cmd_ready, cmd_load = 0;
    logic pause, emu_ram_se, emu_ram_sd;
    word_t emu_ram_di, emu_ram_do = '0;
    logic dout_valid, dout_ready = 0;
    word_t dout_data;
    logic din_valid = 0, din_ready;
    word_t din_data = '0;
    logic busy, done;

    emu_ram_ckpt_ctrl #(.DATA_WIDTH(DW), .CHAIN_WORDS(CW), .SAVE_LAT(LAT)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_load(cmd_load), .pause(pause), .emu_ram_se(emu_ram_se),
        .emu_ram_sd(emu_ram_sd), .emu_ram_di(emu_ram_di), .emu_ram_do(emu_ram_do),
        .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
        .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
        .busy(busy), .done(done));

    always #5 clk = ~clk;

    int total = 0, bad = 0;
    word_t ram [CW];
    word_t orig [CW];
    word_t exp_q[$], got_q[$], loaded[$], din_src[$], src_copy[$];
    int n = 0, occ = 0, rdy_mode = 0, cyc = 0;
    int pause_cyc = 0, done_cnt = 0, busy_viol = 0, full_viol = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic word_t rnd_word();
        return word_t'({$urandom, $urandom, $urandom});
    endfunction

    // Chain model + scoreboard monitor: observe at negedge, advance model just after posedge
    always begin
        logic s_se, s_sd, s_pause, s_hs, s_push, s_pop;
        word_t s_di, e;
        @(negedge clk);
        s_se = emu_ram_se; s_sd = emu_ram_sd; s_di = emu_ram_di; s_pause = pause;
        s_hs = din_valid && din_ready;
        s_pop = dout_valid && dout_ready;
        s_push = emu_ram_se && !emu_ram_sd && (n >= LAT);
        if (pause) pause_cyc++;
        if (done) done_cnt++;
        if (cmd_ready && busy) busy_viol++;
        if (s_push && occ >= 4) full_viol++;
        if (s_pop) begin
            got_q.push_back(dout_data);
            if (exp_q.size() == 0) chk("dout_unexpected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("dout_word", dout_data, e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst || !s_pause) begin
            n = 0; occ = 0;
        end else begin
            if (s_se && s_sd) loaded.push_back(s_di);
            if (s_se) n++;
            occ = occ + (s_push ? 1 : 0) - (s_pop ? 1 : 0);
        end
        if (s_pop && rst) occ = 0;
        if (s_hs && !rst && din_src.size() > 0) void'(din_src.pop_front());
        din_valid = (din_src.size() > 0) && ($urandom_range(3) != 0);
        din_data  = (din_src.size() > 0) ? din_src[0] : rnd_word();
        case (rdy_mode)
            0: dout_ready = 1'b1;
            1: dout_ready = ((cyc / 3) % 2) == 0;
            default: dout_ready = $urandom_range(1) == 1;
        endcase
        if (n >= LAT && n - LAT < CW) emu_ram_do = ram[n - LAT];
        else emu_ram_do = rnd_word();
    end

    task automatic run_op(input bit ld, input bit hold, input int mode, input int exp_pause);
        int d0;
        rdy_mode = mode;
        pause_cyc = 0; busy_viol = 0; full_viol = 0;
        loaded.delete(); got_q.delete();
        if (!ld) for (int i = 0; i < CW; i++) exp_q.push_back(ram[i]);
        d0 = done_cnt;
        @(posedge clk); #2;
        cmd_valid = 1; cmd_load = ld;
        @(posedge clk); #2;
        if (!hold) cmd_valid = 0;
        for (int c = 0; c < 2000 && done_cnt == d0; c++) @(posedge clk);
        #2;
        cmd_valid = 0;
        chk("done_once", done_cnt - d0, 1);
        chk("cmd_ready_while_busy", busy_viol, 0);
        if (!ld) begin
            chk("save_words_left", exp_q.size(), 0);
            chk("save_word_count", got_q.size(), CW);
            chk("se_while_full", full_viol, 0);
            exp_q.delete();
        end else begin
            chk("load_word_count", loaded.size(), CW + 1);
            if (loaded.size() == CW + 1) begin
                chk("flush_word_zero", loaded[CW], 0);
                for (int i = 0; i < CW; i++) ram[i] = loaded[i];
            end
        end
        if (exp_pause > 0) chk("pause_cycles", pause_cyc, exp_pause);
        repeat (3) @(posedge clk);
        #2;
        chk("idle_after_op", {busy, pause, cmd_ready, done_cnt - d0}, {1'b0, 1'b0, 1'b1, 32'd1});
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < CW; i++) ram[i] = word_t'(32'h100 + i);
        repeat (3) @(posedge clk);
        #2;
        chk("reset_outputs", {pause, emu_ram_se, emu_ram_sd, emu_ram_di, dout_valid, din_ready, busy, done}, '0);
        rst = 0;
        @(posedge clk); #2;
        chk("cmd_ready_after_reset", cmd_ready, 1);

        // Basic save with free-flowing output: 0x100..0x10F, 1+2+16+2 pause cycles
        run_op(0, 0, 0, 1 + LAT + CW + 2);
        // Output stalls every 3 cycles
        run_op(0, 0, 1, 0);

        // Load with random din gaps; di stream must equal din stream plus a zero flush
        din_src.delete();
        for (int i = 0; i < CW; i++) din_src.push_back(rnd_word());
        src_copy = din_src;
        run_op(1, 0, 0, 0);
        for (int i = 0; i < CW; i++) chk("load_di_seq", ram[i], src_copy[i]);

        // cmd_valid held through the whole operation is ignored until IDLE
        run_op(0, 1, 2, 0);

        // Save/load round trips restore the RAM bit for bit
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < CW; i++) ram[i] = rnd_word();
            orig = ram;
            run_op(0, 0, 2, 0);
            din_src = got_q;
            for (int i = 0; i < CW; i++) ram[i] = rnd_word();
            run_op(1, 0, 2, 0);
            for (int i = 0; i < CW; i++) chk("roundtrip_ram", ram[i], orig[i]);
        end

        // Reset while word 7 is being scanned out
        begin
            int d0;
            for (int i = 0; i < CW; i++) ram[i] = word_t'(32'h100 + i);
            rdy_mode = 0;
            for (int i = 0; i < CW; i++) exp_q.push_back(ram[i]);
            d0 = done_cnt;
            @(posedge clk); #2;
            cmd_valid = 1; cmd_load = 0;
            @(posedge clk); #2;
            cmd_valid = 0;
            for (int c = 0; c < 200 && n != LAT + 7; c++) @(negedge clk);
            chk("reached_word7", n, LAT + 7);
            #2;
            rst = 1;
            #1;
            chk("reset_mid_outputs", {pause, emu_ram_se, emu_ram_sd, emu_ram_di, dout_valid, din_ready, busy, done}, '0);
            exp_q.delete();
            repeat (2) @(posedge clk);
            #2;
            rst = 0;
            #1;
            chk("no_done_on_reset", done_cnt - d0, 0);
            chk("cmd_ready_after_mid_reset", cmd_ready, 1);
            run_op(0, 0, 0, 1 + LAT + CW + 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
